// File: rtl/st7789_spi_sink.sv
`default_nettype none
// ============================================================================
// Module   : st7789_spi_sink
// Purpose  : Receive-side decoder for the 4-wire ST7789 SPI stream. The SPI
//            lines are oversampled in the clk domain. Bytes are assembled
//            MSB first, and the CASET/RASET window and RAMWR pixel stream are
//            tracked to produce addressed RGB565 pixels.
// Ports    : clk, reset         - system clock, synchronous active-high reset
//            oled_csn/clk/mosi  - SPI chip select (low), clock, data (async)
//            oled_dc            - 0 = command byte, 1 = data byte
//            oled_resn          - panel reset, active low (async)
//            cmd_valid/cmd      - command byte pulse / last command byte
//            data_valid/data    - non-pixel data byte pulse / last data byte
//            pix_valid/pix_x/pix_y/pix_color - completed pixel and address
//            err                - framing error pulse (partial byte at csn rise)
// Options  : ST7789_SINK_ERR_EN - when defined, err reports partial bytes;
//            otherwise err is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module st7789_spi_sink #(
  parameter int C_x_bits = 8,
  parameter int C_y_bits = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                oled_csn,
  input  logic                oled_clk,
  input  logic                oled_mosi,
  input  logic                oled_dc,
  input  logic                oled_resn,
  output logic                cmd_valid,
  output logic [7:0]          cmd,
  output logic                data_valid,
  output logic [7:0]          data,
  output logic                pix_valid,
  output logic [C_x_bits-1:0] pix_x,
  output logic [C_y_bits-1:0] pix_y,
  output logic [15:0]         pix_color,
  output logic                err
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CASET  = 3'd1;
  localparam logic [2:0] S_RASET  = 3'd2;
  localparam logic [2:0] S_RAM_HI = 3'd3;
  localparam logic [2:0] S_RAM_LO = 3'd4;

  localparam logic [7:0] C_CMD_CASET = 8'h2A;
  localparam logic [7:0] C_CMD_RASET = 8'h2B;
  localparam logic [7:0] C_CMD_RAMWR = 8'h2C;

  // --------------------------------------------------------------------------
  // Input synchronizers. Bit [1] of each chain is the usable synchronized
  // value. The SPI clock chain and its edge-detect stage reset high so that
  // an idle-high (mode 3) line does not produce a false rising edge when
  // reset is released.
  // --------------------------------------------------------------------------
  logic [1:0] r_csn_sync;
  logic [1:0] r_sclk_sync;
  logic [1:0] r_mosi_sync;
  logic [1:0] r_dc_sync;
  logic [1:0] r_resn_sync;
  logic       r_sclk_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_csn_sync  <= 2'b11;
      r_sclk_sync <= 2'b11;
      r_sclk_d    <= 1'b1;
      r_mosi_sync <= 2'b00;
      r_dc_sync   <= 2'b00;
      r_resn_sync <= 2'b00;
    end else begin
      r_csn_sync  <= {r_csn_sync[0],  oled_csn};
      r_sclk_sync <= {r_sclk_sync[0], oled_clk};
      r_sclk_d    <= r_sclk_sync[1];
      r_mosi_sync <= {r_mosi_sync[0], oled_mosi};
      r_dc_sync   <= {r_dc_sync[0],   oled_dc};
      r_resn_sync <= {r_resn_sync[0], oled_resn};
    end
  end

  logic w_csn;
  logic w_mosi;
  logic w_dc;
  logic w_rise;
  logic w_clear;

  assign w_csn   = r_csn_sync[1];
  assign w_mosi  = r_mosi_sync[1];
  assign w_dc    = r_dc_sync[1];
  assign w_rise  = r_sclk_sync[1] & ~r_sclk_d;
  // Panel reset clears the decoder exactly like the system reset.
  assign w_clear = reset | ~r_resn_sync[1];

  // --------------------------------------------------------------------------
  // Byte assembly. The 8th bit is merged directly into the latched byte, so
  // only seven bits of history are kept.
  // --------------------------------------------------------------------------
  logic [6:0] r_shift;
  logic [2:0] r_bit_cnt;
  logic       r_byte_stb;
  logic [7:0] r_byte;
  logic       r_byte_dc;

  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_shift    <= 7'd0;
      r_bit_cnt  <= 3'd0;
      r_byte_stb <= 1'b0;
      r_byte     <= 8'd0;
      r_byte_dc  <= 1'b0;
    end else begin
      r_byte_stb <= 1'b0;
      if (w_csn) begin
        r_bit_cnt <= 3'd0;
      end else if (w_rise) begin
        r_shift <= {r_shift[5:0], w_mosi};
        if (r_bit_cnt == 3'd7) begin
          r_bit_cnt  <= 3'd0;
          r_byte_stb <= 1'b1;
          r_byte     <= {r_shift, w_mosi};
          r_byte_dc  <= w_dc;
        end else begin
          r_bit_cnt <= r_bit_cnt + 3'd1;
        end
      end
    end
  end

`ifdef ST7789_SINK_ERR_EN
  // A csn rising edge that finds a partially assembled byte is a framing
  // error. The partial byte is discarded by the counter clear above.
  logic r_csn_d;
  logic r_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_csn_d <= 1'b1;
      r_err   <= 1'b0;
    end else begin
      r_csn_d <= w_csn;
      r_err   <= r_resn_sync[1] & w_csn & ~r_csn_d & (r_bit_cnt != 3'd0);
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Command decoder, address window and pixel walker.
  // --------------------------------------------------------------------------
  logic [2:0]          r_state;
  logic [1:0]          r_param_idx;
  logic [7:0]          r_p0;
  logic [7:0]          r_p1;
  logic [7:0]          r_p2;
  logic [7:0]          r_pix_hi;
  logic [C_x_bits-1:0] r_xs;
  logic [C_x_bits-1:0] r_xe;
  logic [C_y_bits-1:0] r_ys;
  logic [C_y_bits-1:0] r_ye;
  logic [C_x_bits-1:0] r_x;
  logic [C_y_bits-1:0] r_y;

  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_state     <= S_IDLE;
      r_param_idx <= 2'd0;
      r_p0        <= 8'd0;
      r_p1        <= 8'd0;
      r_p2        <= 8'd0;
      r_pix_hi    <= 8'd0;
      r_xs        <= '0;
      r_xe        <= '1;
      r_ys        <= '0;
      r_ye        <= '1;
      r_x         <= '0;
      r_y         <= '0;
      cmd_valid   <= 1'b0;
      cmd         <= 8'd0;
      data_valid  <= 1'b0;
      data        <= 8'd0;
      pix_valid   <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      pix_color   <= 16'd0;
    end else begin
      cmd_valid  <= 1'b0;
      data_valid <= 1'b0;
      pix_valid  <= 1'b0;
      if (r_byte_stb) begin
        if (!r_byte_dc) begin
          // Any command aborts the current state. A pending high byte is
          // simply abandoned.
          cmd_valid   <= 1'b1;
          cmd         <= r_byte;
          r_param_idx <= 2'd0;
          case (r_byte)
            C_CMD_CASET: r_state <= S_CASET;
            C_CMD_RASET: r_state <= S_RASET;
            C_CMD_RAMWR: begin
              r_state <= S_RAM_HI;
              r_x     <= r_xs;
              r_y     <= r_ys;
            end
            default:     r_state <= S_IDLE;
          endcase
        end else begin
          case (r_state)
            S_RAM_HI: begin
              r_pix_hi <= r_byte;
              r_state  <= S_RAM_LO;
            end
            S_RAM_LO: begin
              pix_valid <= 1'b1;
              pix_x     <= r_x;
              pix_y     <= r_y;
              pix_color <= {r_pix_hi, r_byte};
              r_state   <= S_RAM_HI;
              // Equality-only compares: a start beyond the end wraps through
              // the counter maximum.
              if (r_x == r_xe) begin
                r_x <= r_xs;
                r_y <= (r_y == r_ye) ? r_ys : r_y + 1'b1;
              end else begin
                r_x <= r_x + 1'b1;
              end
            end
            S_CASET, S_RASET: begin
              data_valid  <= 1'b1;
              data        <= r_byte;
              r_param_idx <= r_param_idx + 2'd1;
              case (r_param_idx)
                2'd0: r_p0 <= r_byte;
                2'd1: r_p1 <= r_byte;
                2'd2: r_p2 <= r_byte;
                default: begin
                  // Both window edges update together on the last parameter.
                  if (r_state == S_CASET) begin
                    r_xs <= C_x_bits'({r_p0, r_p1});
                    r_xe <= C_x_bits'({r_p2, r_byte});
                  end else begin
                    r_ys <= C_y_bits'({r_p0, r_p1});
                    r_ye <= C_y_bits'({r_p2, r_byte});
                  end
                  r_state <= S_IDLE;
                end
              endcase
            end
            default: begin
              data_valid <= 1'b1;
              data       <= r_byte;
            end
          endcase
        end
      end
    end
  end

endmodule
`default_nettype wire
